// File: rtl/mmul_frame_sequencer.sv
// mmul_frame_sequencer
// Steers one AXI4-Stream frame (N weight rows, then activation rows ending in
// TLAST) into the systolic matrix-multiply top level. It then appends
// FLUSH_BEATS zero beats so the skew/grid/deskew pipeline drains.
// Optional build macro: MMUL_SEQ_WEIGHT_REUSE_EN. When it is defined, a frame
// may skip its weight phase if reuse_weights is high at frame start.
module mmul_frame_sequencer #(
   parameter int N           = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int FLUSH_BEATS = 10,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [N*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    load_weight,
   input  logic                    reuse_weights,
   output logic [CNT_WIDTH-1:0]    act_count,
   output logic                    frame_done,
   output logic                    err_short_frame
);

   localparam int WCNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int FCNT_W = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

   typedef enum logic [1:0] {
      ST_WEIGHTS = 2'd0,
      ST_ACTS    = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t                state_q, state_d, eff_state, next_frame_state;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
   logic [CNT_WIDTH-1:0]  act_cnt_q, act_cnt_d;
   logic                  act_restart_q, act_restart_d;
   logic                  err_q, err_d;
   logic                  xfer;

`ifdef MMUL_SEQ_WEIGHT_REUSE_EN
   logic init_pend_q;

   // Marks the first cycle after reset, when reuse_weights decides the first frame's phase
   always_ff @(posedge clk or posedge reset) begin
      if (reset) init_pend_q <= 1'b1;
      else       init_pend_q <= 1'b0;
   end

   assign eff_state = (state_q == ST_WEIGHTS && init_pend_q && reuse_weights) ?
                      ST_ACTS : state_q;
   assign next_frame_state = reuse_weights ? ST_ACTS : ST_WEIGHTS;
`else
   logic reuse_unused;
   assign reuse_unused     = reuse_weights;
   assign eff_state        = state_q;
   assign next_frame_state = ST_WEIGHTS;
`endif

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_WEIGHTS;
         wcnt_q        <= '0;
         fcnt_q        <= '0;
         act_cnt_q     <= '0;
         act_restart_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         fcnt_q        <= fcnt_d;
         act_cnt_q     <= act_cnt_d;
         act_restart_q <= act_restart_d;
         err_q         <= err_d;
      end
   end

   // Stream steering, phase transitions and counter updates
   always_comb begin
      state_d       = eff_state;
      wcnt_d        = wcnt_q;
      fcnt_d        = fcnt_q;
      act_cnt_d     = act_cnt_q;
      act_restart_d = act_restart_q;
      err_d         = err_q;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tvalid = s_axis_tvalid;
      s_axis_tready = m_axis_tready;
      load_weight   = 1'b0;
      frame_done    = 1'b0;
      xfer          = 1'b0;

      case (eff_state)
         ST_WEIGHTS: begin
            load_weight = 1'b1;
            xfer        = s_axis_tvalid && m_axis_tready;
            if (xfer) begin
               if (s_axis_tlast) begin
                  // Frame ended inside the weight phase: flag it and restart weights
                  err_d  = 1'b1;
                  wcnt_d = '0;
               end else if (wcnt_q == WCNT_W'(N - 1)) begin
                  wcnt_d  = '0;
                  state_d = ST_ACTS;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end

         ST_ACTS: begin
            xfer = s_axis_tvalid && m_axis_tready;
            if (xfer) begin
               // The count holds the previous frame's total until this frame's first beat
               if (act_restart_q)
                  act_cnt_d = CNT_WIDTH'(1);
               else if (act_cnt_q != '1)
                  act_cnt_d = act_cnt_q + 1'b1;
               act_restart_d = 1'b0;
               if (s_axis_tlast) begin
                  state_d       = ST_FLUSH;
                  act_restart_d = 1'b1;
               end
            end
         end

         ST_FLUSH: begin
            s_axis_tready = 1'b0;
            m_axis_tdata  = '0;
            m_axis_tvalid = 1'b1;
            xfer          = m_axis_tready;
            if (xfer) begin
               if (fcnt_q == FCNT_W'(FLUSH_BEATS - 1)) begin
                  frame_done = 1'b1;
                  fcnt_d     = '0;
                  state_d    = next_frame_state;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_WEIGHTS;
         end
      endcase
   end

   assign act_count       = act_cnt_q;
   assign err_short_frame = err_q;

endmodule

// File: tb/tb_mmul_frame_sequencer.sv
// tb_mmul_frame_sequencer
// Directed and randomized frames for mmul_frame_sequencer. The reference is a
// per-frame list of expected downstream beats: weight rows, activation rows and
// then zero flush beats. Build with +define+MMUL_SEQ_WEIGHT_REUSE_EN to model
// the weight-reuse option.
module tb_mmul_frame_sequencer;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int FB      = 10;
   localparam int CW      = 16;
   localparam int BW      = N * DW;
   localparam int ACT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [BW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic [BW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          load_weight;
   logic          reuse_weights = 1'b0;
   logic [CW-1:0] act_count;
   logic          frame_done;
   logic          err_short_frame;

   mmul_frame_sequencer #(
      .N(N), .DATA_WIDTH(DW), .FLUSH_BEATS(FB), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .load_weight(load_weight),
      .reuse_weights(reuse_weights), .act_count(act_count),
      .frame_done(frame_done), .err_short_frame(err_short_frame)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [BW-1:0] data;
      bit            lw;
      bit            flush;
      bit            done;
   } exp_t;

   typedef struct {
      logic [BW-1:0] data;
      bit            last;
   } src_t;

   exp_t exp_q[$];
   src_t src_q[$];
   bit   skip_next = 1'b0;
   int   act_exp   = 0;
   int   frame_len = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected frame: nw weight rows (or none when the weights are reused),
   // na activation rows with tlast on the last one, then FB zero beats.
   // A short frame has tlast on its last weight row and produces no flush.
   task automatic build_frame(input int nw, input int na, input bit short_frame);
      int            w;
      logic [BW-1:0] d;
      src_t          s;
      exp_t          e;
      w = (skip_next && !short_frame) ? 0 : nw;
      for (int i = 0; i < w; i++) begin
         d = BW'($urandom);
         s.data = d; s.last = short_frame && (i == w - 1);
         src_q.push_back(s);
         e.data = d; e.lw = 1'b1; e.flush = 1'b0; e.done = 1'b0;
         exp_q.push_back(e);
      end
      if (!short_frame) begin
         for (int i = 0; i < na; i++) begin
            d = BW'($urandom);
            s.data = d; s.last = (i == na - 1);
            src_q.push_back(s);
            e.data = d; e.lw = 1'b0; e.flush = 1'b0; e.done = 1'b0;
            exp_q.push_back(e);
         end
         for (int i = 0; i < FB; i++) begin
            e.data = '0; e.lw = 1'b0; e.flush = 1'b1; e.done = (i == FB - 1);
            exp_q.push_back(e);
         end
         act_exp = (na > ACT_MAX) ? ACT_MAX : na;
      end
      frame_len = exp_q.size();
   endtask

   // Plays the source and the sink until the expected beats are consumed.
   // mode: 0 ready always, 1 ready toggles 1,0,1,..., 2 random ready.
   // vgap: random idle cycles from the source. abort_flush>0: return once that
   // many flush beats have transferred.
   task automatic run(input int mode, input int vgap, input int abort_flush, input int budget);
      int   cyc = 0;
      int   nflush = 0;
      int   xfers = 0;
      bit   held = 1'b0;
      bit   sv, xf, taken;
      exp_t e;
      while (exp_q.size() > 0 && cyc < budget) begin
         if (abort_flush > 0 && nflush == abort_flush) return;
         sv = held || (src_q.size() > 0 && (vgap == 0 || $urandom_range(0, 3) != 0));
         s_axis_tvalid = sv;
         s_axis_tdata  = sv ? src_q[0].data : '0;
         s_axis_tlast  = sv ? src_q[0].last : 1'b0;
         case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         e  = exp_q[0];
         xf = m_axis_tvalid && m_axis_tready;
         if (e.flush) begin
            chk("flush_tvalid", m_axis_tvalid, 1'b1);
            chk("flush_s_tready", s_axis_tready, 1'b0);
         end else begin
            chk("pass_tvalid", m_axis_tvalid, s_axis_tvalid);
            chk("pass_s_tready", s_axis_tready, m_axis_tready);
         end
         chk("load_weight", load_weight, e.lw);
         chk("frame_done", frame_done, xf && e.done);
         if (xf) begin
            chk("m_tdata", m_axis_tdata, e.data);
            void'(exp_q.pop_front());
            xfers++;
            if (e.flush) nflush++;
            if (e.done) begin
               chk("frame_xfers", xfers, frame_len);
`ifdef MMUL_SEQ_WEIGHT_REUSE_EN
               skip_next = reuse_weights;
`else
               skip_next = 1'b0;
`endif
            end
         end
         taken = sv && s_axis_tready;
         @(posedge clk);
         if (taken) void'(src_q.pop_front());
         held = sv && !taken;
         #1;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      chk("frame_drained", exp_q.size(), 0);
   endtask

   initial begin
      if (FB < 1) begin
         $display("FAIL flush_beats_param: FLUSH_BEATS=%0d must be at least 1", FB);
         $fatal(1);
      end

      // Reset state, observed while reset is still asserted
      #1;
      chk("rst_load_weight", load_weight, 1'b1);
      chk("rst_act_count", act_count, 0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_err", err_short_frame, 1'b0);
      chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
      m_axis_tready = 1'b1;
      #1;
      chk("rst_s_tready", s_axis_tready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;

      // Basic 4+3 frame, sink always ready
      build_frame(4, 3, 1'b0);
      run(0, 0, 0, 200);
      chk("t1_act_count", act_count, act_exp);
      chk("t1_err", err_short_frame, 1'b0);

      // Same shape with the sink ready toggling every cycle
      build_frame(4, 3, 1'b0);
      run(1, 0, 0, 200);
      chk("t2_act_count", act_count, act_exp);

      // tlast on the 2nd weight row, then a good 4+2 frame
      build_frame(2, 0, 1'b1);
      run(0, 0, 0, 50);
      @(negedge clk);
      chk("t3_err_set", err_short_frame, 1'b1);
      chk("t3_still_weights", load_weight, 1'b1);
      @(posedge clk); #1;
      build_frame(4, 2, 1'b0);
      run(0, 0, 0, 200);
      chk("t3_act_count", act_count, 2);
      chk("t3_err_sticky", err_short_frame, 1'b1);

      // Asynchronous reset in the middle of flush beat 5
      build_frame(4, 3, 1'b0);
      run(0, 0, 4, 200);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("t4_m_tvalid", m_axis_tvalid, 1'b0);
      chk("t4_s_tready", s_axis_tready, 1'b1);
      chk("t4_load_weight", load_weight, 1'b1);
      chk("t4_act_count", act_count, 0);
      chk("t4_err", err_short_frame, 1'b0);
      chk("t4_frame_done", frame_done, 1'b0);
      exp_q.delete();
      src_q.delete();
      skip_next = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      build_frame(4, 3, 1'b0);
      run(0, 0, 0, 200);
      chk("t4_after_act_count", act_count, 3);

      // Weight reuse held high across two 4+2 frames
      reuse_weights = 1'b1;
      build_frame(4, 2, 1'b0);
      run(0, 0, 0, 200);
      chk("t5_a_act_count", act_count, 2);
      build_frame(4, 2, 1'b0);
`ifdef MMUL_SEQ_WEIGHT_REUSE_EN
      chk("t5_b_len_no_weights", frame_len, 2 + FB);
`else
      chk("t5_b_len_with_weights", frame_len, 4 + 2 + FB);
`endif
      run(0, 0, 0, 200);
      chk("t5_b_act_count", act_count, 2);
      reuse_weights = 1'b0;

      // Randomized frames with random backpressure and source gaps
      for (int k = 0; k < 6; k++) begin
         build_frame(4, $urandom_range(1, 9), 1'b0);
         run(2, 1, 0, 1000);
         chk("t6_act_count", act_count, act_exp);
      end

      // Activation count saturation
      build_frame(4, 70000, 1'b0);
      run(0, 0, 0, 70100);
      chk("t7_act_saturated", act_count, ACT_MAX);
      chk("t7_err", err_short_frame, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmul_frame_sequencer.md
Name: mmul_frame_sequencer

Overview:
- Upstream stage of the systolic matrix-multiply top level. Consumes one AXI4-Stream frame per matrix product: N weight rows, then K activation rows ending in TLAST.
- Drives the top level's slave stream and its load_weight control, then appends zero flush beats so the skew/grid/deskew pipeline drains every result for the frame.
- Pure stream steering plus a small state machine; no data storage beyond counters.

Parameters:
- N, 4, array dimension; beats in the weight phase.
- DATA_WIDTH, 8, width of one element; beat width is N*DATA_WIDTH.
- FLUSH_BEATS, 10, number of zero beats appended after the last activation beat (3*N-2 for the default pipeline).
- CNT_WIDTH, 16, width of the activation-beat counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  N*DATA_WIDTH  frame beats from the host/DMA.
- s_axis_tvalid  input  1  upstream valid.
- s_axis_tlast  input  1  marks the last activation beat of a frame.
- s_axis_tready  output  1  upstream ready.
- m_axis_tdata  output  N*DATA_WIDTH  beats to the array top level.
- m_axis_tvalid  output  1  downstream valid.
- m_axis_tready  input  1  downstream ready.
- load_weight  output  1  high while the beat on m_axis is a weight row.
- reuse_weights  input  1  skip weight phase (used only with the optional feature).
- act_count  output  CNT_WIDTH  activation beats accepted in the current/last frame.
- frame_done  output  1  one-cycle pulse on the final flush handshake.
- err_short_frame  output  1  sticky error flag.

Behaviour:
- Reset (async, any time, including mid-frame): state=WEIGHTS, weight counter=0, flush counter=0, act_count=0, frame_done=0, err_short_frame=0. Outputs immediately reflect the WEIGHTS state.
- Handshake: a beat transfers when m_axis_tvalid && m_axis_tready. In WEIGHTS and ACTS the path is combinational pass-through, with zero added latency:
  - m_axis_tdata=s_axis_tdata
  - m_axis_tvalid=s_axis_tvalid
  - s_axis_tready=m_axis_tready
- WEIGHTS: load_weight=1.
  - Each transfer increments the weight counter.
  - On the N-th transfer, go to ACTS and clear the counter.
  - tlast on any weight transfer: set err_short_frame, clear the counter and stay in WEIGHTS; that beat is still forwarded.
- ACTS: load_weight=0.
  - Each transfer increments act_count, saturating at all-ones.
  - A transfer with tlast goes to FLUSH.
  - act_count is cleared on the first ACTS transfer of the next frame, not at frame end, so it holds the last frame's total.
- FLUSH:
  - s_axis_tready=0, m_axis_tdata=0, m_axis_tvalid=1, load_weight=0.
  - Each transfer increments the flush counter.
  - On transfer FLUSH_BEATS: pulse frame_done for that cycle, clear the counter and go to WEIGHTS.
  - m_axis_tvalid must not drop until that transfer completes (AXI stability).
- Backpressure: m_axis_tready low stalls every state with no counter change. Upstream tdata/tvalid stability is the upstream's responsibility.
- err_short_frame clears only on reset.
- FLUSH_BEATS=0 is illegal; the bench checks FLUSH_BEATS>=1.

Optional Feature:
- Macro MMUL_SEQ_WEIGHT_REUSE_EN.
- Defined: reuse_weights is sampled on the FLUSH->WEIGHTS transition and after reset. When it is 1, the next frame starts in ACTS with no weight phase, and the array keeps its previous weights.
- Undefined: reuse_weights is ignored and every frame starts in WEIGHTS.

Test Plan:
- N=4, frame of 4 weight beats and 3 activation beats (tlast on the 3rd), m_axis_tready=1 -> exact sequence:
  - beats 1-4 forwarded with load_weight=1
  - beats 5-7 forwarded with load_weight=0
  - s_axis_tready=0 for the next 10 cycles, each with m_axis_tdata=0
  - frame_done pulses on cycle 10 of the flush
  - act_count=3
- Same frame with m_axis_tready toggled 1,0,1,0,... -> identical beat order and values, no duplicated or dropped beat, and frame_done after exactly 17 transfers.
- tlast on 2nd weight beat -> err_short_frame=1 stays high, state WEIGHTS; a following valid 4+2 frame completes normally with act_count=2.
- Assert reset during FLUSH beat 5 -> all outputs return to reset values asynchronously; the next frame starts with load_weight=1 and a full 4-beat weight phase.
- 70000 activation beats in one frame with CNT_WIDTH=16 -> act_count saturates at 65535.
- With MMUL_SEQ_WEIGHT_REUSE_EN and reuse_weights=1 held, two back-to-back 4+2 frames -> second frame has no load_weight beats and its first beat counts as activation (act_count=2 after each frame); without the macro the second frame has a 4-beat weight phase.
